// File: rtl/fetch_unit.sv
// fetch_unit: parametrised instruction fetch with a {pc,inst} buffer toward decode and redirect/flush.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              IADDR_W    = 8,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [IADDR_W-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [31:0]        dec_inst_o,
  output logic [XLEN-1:0]    dec_pc_o,
  output logic [31:0]        monitor_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_o,
  output logic [31:0]        perf_stall_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, req_pc_q;
  logic            inflight_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0]     fifo_inst [FIFO_DEPTH];
  logic            push, pop;

  // Issue only when the outstanding response is guaranteed a free slot; flush beats push and pop.
  always_comb begin
    dec_valid_o = count_q != '0;
    push        = inflight_q && !redirect_i;
    pop         = dec_valid_o && dec_ready_i && !redirect_i;
    imem_req_o  = rst_ni && !redirect_i &&
                  (({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH));
    imem_addr_o = pc_q[IADDR_W+1:2];
    dec_inst_o  = dec_valid_o ? fifo_inst[rptr_q] : '0;
    dec_pc_o    = dec_valid_o ? fifo_pc[rptr_q] : '0;
    monitor_o   = dec_inst_o;
  end

  // PC, in-flight flag and the PC of the outstanding request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i & ~XLEN'(3);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + XLEN'(4);
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; contents are masked by dec_valid_o so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wptr_q]   <= req_pc_q;
      fifo_inst[wptr_q] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_EN
  // Accepted-pop and decode-stall counters, untouched by redirect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (pop) perf_fetch_o <= perf_fetch_o + 32'd1;
      if (dec_valid_o && !dec_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-based reference model plus directed literal checks for fetch_unit.
module tb_fetch_unit;
  logic        clk = 1'b0, rst_ni = 1'b0, redirect = 1'b0, ready = 1'b1;
  logic [31:0] rpc = '0;
  logic        req, valid, req2, valid2;
  logic [7:0]  addr, addr2;
  logic [31:0] rdata = '0, rdata2 = '0, inst, pc, mon, inst2, pc2, mon2;
  logic [31:0] mem [256];
  int          checks = 0, errors = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] pf, ps, pf2, ps2;
`endif

  fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_ni), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .redirect_i(redirect), .redirect_pc_i(rpc),
    .dec_valid_o(valid), .dec_ready_i(ready), .dec_inst_o(inst),
    .dec_pc_o(pc), .monitor_o(mon)
`ifdef FETCH_PERF_EN
    , .perf_fetch_o(pf), .perf_stall_o(ps)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(rdata2), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .dec_valid_o(valid2), .dec_ready_i(1'b1), .dec_inst_o(inst2),
    .dec_pc_o(pc2), .monitor_o(mon2)
`ifdef FETCH_PERF_EN
    , .perf_fetch_o(pf2), .perf_stall_o(ps2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req) rdata <= mem[addr];
    if (req2) rdata2 <= mem[addr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of buffered PCs, the next PC and the PC of a pending response.
  logic [31:0] q[$];
  logic [31:0] m_pc = '0, m_rpc = '0;
  bit          m_inf = 0;

  function automatic bit m_req();
    return rst_ni && !redirect && (q.size() + int'(m_inf) < 4);
  endfunction

  function automatic void model_step();
    bit r;
    r = m_req();
    if (redirect) begin
      q.delete();
      m_pc  = rpc & ~32'h3;
      m_inf = 0;
    end else begin
      if (q.size() > 0 && ready) void'(q.pop_front());
      if (m_inf) q.push_back(m_rpc);
      if (r) begin
        m_rpc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
      m_inf = r;
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pc  = '0;
    m_inf = 0;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) model_reset();
    else model_step();
  end

  // Compare the DUT against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    logic [31:0] e_pc, e_inst;
    e_pc   = q.size() > 0 ? q[0] : 32'h0;
    e_inst = q.size() > 0 ? mem[e_pc[9:2]] : 32'h0;
    chk("m_valid", 32'(valid), 32'(q.size() > 0));
    chk("m_pc", pc, e_pc);
    chk("m_inst", inst, e_inst);
    chk("m_mon", mon, e_inst);
    chk("m_req", 32'(req), 32'(m_req()));
    if (m_req()) chk("m_addr", 32'(addr), 32'(m_pc[9:2]));
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_req2", 32'(req2), 0);
    // Scenario 1 and 5: streaming from reset, including PC wrap on dut2.
    @(posedge clk); #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("s1_req0", 32'(req), 1);
    chk("s1_addr0", 32'(addr), 0);
    chk("s1_valid0", 32'(valid), 0);
    @(negedge clk);
    chk("s1_valid1", 32'(valid), 0);
    chk("s1_addr1", 32'(addr), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s1_valid", 32'(valid), 1);
      chk("s1_pc", pc, 32'(i * 4));
      chk("s1_inst", inst, 32'(i));
      chk("s5_pc", pc2, 32'hFFFF_FFF8 + 32'(i * 4));
      chk("s5_inst", inst2, 32'((254 + i) % 256));
    end
    // Scenario 2: decode stalled from reset, buffer fills to four entries.
    @(posedge clk); #2 rst_ni = 1'b0; ready = 1'b0;
    @(posedge clk); #2 rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    chk("s2_req", 32'(req), 0);
    chk("s2_valid", 32'(valid), 1);
    chk("s2_pc", pc, 0);
    @(posedge clk); #2 ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s2_valid_rel", 32'(valid), 1);
      chk("s2_pc_rel", pc, 32'(i * 4));
    end
    // Scenario 3: redirect to 0x43 with a partly full buffer.
    @(posedge clk); #2 ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 redirect = 1'b1; rpc = 32'h43;
    @(negedge clk);
    chk("s3_req_in_r", 32'(req), 0);
    @(posedge clk); #2 redirect = 1'b0;
    @(negedge clk);
    chk("s3_valid_r1", 32'(valid), 0);
    chk("s3_req_r1", 32'(req), 1);
    chk("s3_addr_r1", 32'(addr), 32'h10);
    @(negedge clk);
    chk("s3_valid_r2", 32'(valid), 0);
    @(negedge clk);
    chk("s3_valid_r3", 32'(valid), 1);
    chk("s3_pc", pc, 32'h40);
    chk("s3_inst", inst, 32'h10);
    // Scenario 4: redirect during pop with a pending response, then back-to-back redirects.
    @(posedge clk); #2 ready = 1'b1;
    repeat (4) @(posedge clk);
    #2 redirect = 1'b1; rpc = 32'h200;
    @(posedge clk); #2 redirect = 1'b0;
    repeat (4) @(posedge clk);
    #2 redirect = 1'b1; rpc = 32'h80;
    @(posedge clk); #2 rpc = 32'h100;
    @(posedge clk); #2 redirect = 1'b0;
    @(negedge clk);
    chk("s4_valid_r1", 32'(valid), 0);
    chk("s4_addr_r1", 32'(addr), 32'h40);
    @(negedge clk);
    chk("s4_valid_r2", 32'(valid), 0);
    @(negedge clk);
    chk("s4_pc0", pc, 32'h100);
    chk("s4_inst0", inst, 32'h40);
    @(negedge clk);
    chk("s4_pc1", pc, 32'h104);
    chk("s4_inst1", inst, 32'h41);
    // Scenario 6: asynchronous reset with a full buffer.
    @(posedge clk); #2 ready = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    chk("s6_req", 32'(req), 0);
    chk("s6_valid", 32'(valid), 0);
    chk("s6_pc", pc, 0);
    chk("s6_inst", inst, 0);
    chk("s6_mon", mon, 0);
    chk("s6_valid2", 32'(valid2), 0);
    @(posedge clk); #2 rst_ni = 1'b1; ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
